// File: rtl/cpu_trace_monitor.sv
// Observation stage for the multicycle CPU: cycle/fetch counters, a PC trace FIFO
// drained by valid/ready, and sticky overflow, self-loop halt and frozen-FSM stall flags.
module cpu_trace_monitor #(
    parameter logic [5:0]  FETCH_STATE  = 6'd0,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned HALT_REPEAT  = 4,
    parameter int unsigned STALL_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  estado,
    input  logic [31:0] RegPCOut,
    input  logic        clear,
    input  logic        trace_ready,
    output logic        trace_valid,
    output logic [31:0] trace_data,
    output logic [31:0] cycle_count,
    output logic [31:0] fetch_count,
    output logic        trace_overflow,
    output logic        halted,
    output logic        stalled
);

    localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OccW   = $clog2(DEPTH + 1);
    localparam int unsigned RepW   = $clog2(HALT_REPEAT + 1);
    localparam int unsigned StallW = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;

    localparam logic [OccW-1:0]   OccFull   = OccW'(DEPTH);
    localparam logic [RepW-1:0]   RepMax    = RepW'(HALT_REPEAT);
    localparam logic [RepW-1:0]   RepLast   = RepW'(HALT_REPEAT - 1);
    localparam logic [StallW-1:0] StallLast = StallW'(STALL_CYCLES - 1);

    logic [5:0]        prev_estado_q, prev_estado_d;
    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       mem_d [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OccW-1:0]   occ_q, occ_d;
    logic [31:0]       cycle_count_q, cycle_count_d;
    logic [31:0]       fetch_count_q, fetch_count_d;
    logic              overflow_q, overflow_d;
    logic              halted_q, halted_d;
    logic              stalled_q, stalled_d;
    logic [31:0]       last_pc_q, last_pc_d;
    logic              have_last_q, have_last_d;
    logic [RepW-1:0]   repeat_cnt_q, repeat_cnt_d;
    logic [StallW-1:0] stall_cnt_q, stall_cnt_d;

    logic fetch_ev;
    logic same_state;
    logic fifo_full;
    logic pop;
    logic push;
    logic pc_match;

    always_comb begin
        fetch_ev   = (estado == FETCH_STATE) && (prev_estado_q != FETCH_STATE);
        same_state = (estado == prev_estado_q);
        fifo_full  = (occ_q == OccFull);
        pop        = (occ_q != '0) && trace_ready && !clear;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push       = fetch_ev && !clear && (!fifo_full || pop);
        pc_match   = have_last_q && (RegPCOut == last_pc_q);
    end

    always_comb begin
        prev_estado_d = estado;
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        occ_d         = occ_q;
        cycle_count_d = cycle_count_q;
        fetch_count_d = fetch_count_q;
        overflow_d    = overflow_q;
        halted_d      = halted_q;
        stalled_d     = stalled_q;
        last_pc_d     = last_pc_q;
        have_last_d   = have_last_q;
        repeat_cnt_d  = repeat_cnt_q;
        stall_cnt_d   = stall_cnt_q;

        if (clear) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            occ_d         = '0;
            cycle_count_d = '0;
            fetch_count_d = '0;
            overflow_d    = 1'b0;
            halted_d      = 1'b0;
            stalled_d     = 1'b0;
            last_pc_d     = '0;
            have_last_d   = 1'b0;
            repeat_cnt_d  = '0;
            stall_cnt_d   = '0;
        end else begin
            if (cycle_count_q != '1) begin
                cycle_count_d = cycle_count_q + 32'd1;
            end
            if (fetch_ev && (fetch_count_q != '1)) begin
                fetch_count_d = fetch_count_q + 32'd1;
            end

            if (push) begin
                mem_d[wr_ptr_q] = RegPCOut;
                wr_ptr_d        = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                occ_d = occ_q + OccW'(1);
            end else if (!push && pop) begin
                occ_d = occ_q - OccW'(1);
            end
            if (fetch_ev && !push) begin
                overflow_d = 1'b1;
            end

            if (fetch_ev) begin
                if (pc_match) begin
                    if (repeat_cnt_q < RepMax) begin
                        repeat_cnt_d = repeat_cnt_q + RepW'(1);
                    end
                    if (repeat_cnt_q >= RepLast) begin
                        halted_d = 1'b1;
                    end
                end else begin
                    repeat_cnt_d = '0;
                end
                last_pc_d   = RegPCOut;
                have_last_d = 1'b1;
            end

            if (same_state) begin
                if (stall_cnt_q == StallLast) begin
                    stalled_d = 1'b1;
                end else begin
                    stall_cnt_d = stall_cnt_q + StallW'(1);
                end
            end else begin
                stall_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // Any non-fetch code works; the first fetch after reset must register as an event.
            prev_estado_q <= ~FETCH_STATE;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            occ_q         <= '0;
            cycle_count_q <= '0;
            fetch_count_q <= '0;
            overflow_q    <= 1'b0;
            halted_q      <= 1'b0;
            stalled_q     <= 1'b0;
            last_pc_q     <= '0;
            have_last_q   <= 1'b0;
            repeat_cnt_q  <= '0;
            stall_cnt_q   <= '0;
        end else begin
            prev_estado_q <= prev_estado_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
            cycle_count_q <= cycle_count_d;
            fetch_count_q <= fetch_count_d;
            overflow_q    <= overflow_d;
            halted_q      <= halted_d;
            stalled_q     <= stalled_d;
            last_pc_q     <= last_pc_d;
            have_last_q   <= have_last_d;
            repeat_cnt_q  <= repeat_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    always_comb begin
        trace_valid    = (occ_q != '0);
        trace_data     = trace_valid ? mem_q[rd_ptr_q] : '0;
        cycle_count    = cycle_count_q;
        fetch_count    = fetch_count_q;
        trace_overflow = overflow_q;
        halted         = halted_q;
        stalled        = stalled_q;
    end

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Directed bench for cpu_trace_monitor: trace FIFO contents are checked against a
// scoreboard filled as fetch events are driven; flags and counters against constants.
module tb_cpu_trace_monitor;

    localparam logic [5:0] FS    = 6'd0;
    localparam int         Depth = 8;

    logic        clock;
    logic        reset;
    logic [5:0]  estado;
    logic [31:0] RegPCOut;
    logic        clear;
    logic        trace_ready;
    logic        trace_valid;
    logic [31:0] trace_data;
    logic [31:0] cycle_count;
    logic [31:0] fetch_count;
    logic        trace_overflow;
    logic        halted;
    logic        stalled;

    int          checks   = 0;
    int          failures = 0;
    logic [5:0]  m_prev;
    logic [31:0] sb[$];

    cpu_trace_monitor dut (
        .clock          (clock),
        .reset          (reset),
        .estado         (estado),
        .RegPCOut       (RegPCOut),
        .clear          (clear),
        .trace_ready    (trace_ready),
        .trace_valid    (trace_valid),
        .trace_data     (trace_data),
        .cycle_count    (cycle_count),
        .fetch_count    (fetch_count),
        .trace_overflow (trace_overflow),
        .halted         (halted),
        .stalled        (stalled)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_valid"}, {31'b0, trace_valid}, 32'd0);
        chk({pfx, "_data"}, trace_data, 32'd0);
        chk({pfx, "_cycles"}, cycle_count, 32'd0);
        chk({pfx, "_fetches"}, fetch_count, 32'd0);
        chk({pfx, "_overflow"}, {31'b0, trace_overflow}, 32'd0);
        chk({pfx, "_halted"}, {31'b0, halted}, 32'd0);
        chk({pfx, "_stalled"}, {31'b0, stalled}, 32'd0);
    endtask

    // One clock: predict pushes/pops from the inputs now applied, then advance.
    task automatic tick();
        logic [31:0] head;
        bit          ev;
        bit          pop;
        ev  = (estado == FS) && (m_prev != FS);
        pop = (sb.size() != 0) && trace_ready;
        chk("trace_valid", {31'b0, trace_valid}, {31'b0, (sb.size() != 0)});
        if (clear) begin
            sb.delete();
        end else begin
            if (pop) begin
                head = sb.pop_front();
                chk("trace_data", trace_data, head);
            end
            if (ev && (sb.size() < Depth)) sb.push_back(RegPCOut);
        end
        m_prev = estado;
        @(posedge clock);
        #1;
    endtask

    task automatic do_clear();
        clear  = 1'b1;
        estado = 6'd1;
        tick();
        clear  = 1'b0;
    endtask

    task automatic fetch_at(input logic [31:0] pc);
        estado   = FS;
        RegPCOut = pc;
        tick();
        estado   = 6'd1;
        tick();
    endtask

    logic [5:0]  t1_est [7] = '{6'd0, 6'd0, 6'd1, 6'd2, 6'd0, 6'd1, 6'd0};
    logic [31:0] t1_pc  [7] = '{32'h0, 32'h0, 32'h4, 32'h4, 32'h4, 32'h8, 32'h8};

    initial begin
        reset       = 1'b0;
        estado      = 6'd0;
        RegPCOut    = 32'd0;
        clear       = 1'b0;
        trace_ready = 1'b0;
        m_prev      = ~FS;
        repeat (3) @(posedge clock);
        #1;
        chk_all_zero("reset");
        reset = 1'b1;

        // Test 1: entry into the fetch state counts once; PC sampled at each entry
        for (int i = 0; i < 7; i++) begin
            estado   = t1_est[i];
            RegPCOut = t1_pc[i];
            tick();
        end
        chk("t1_fetches", fetch_count, 32'd3);
        chk("t1_cycles", cycle_count, 32'd7);
        chk("t1_head", trace_data, 32'h0);
        estado      = 6'd1;
        trace_ready = 1'b1;
        repeat (3) tick();
        chk("t1_drained", {31'b0, trace_valid}, 32'd0);
        trace_ready = 1'b0;
        do_clear();

        // Test 2: fill, overflow on the ninth, then drain in order
        for (int i = 0; i < 8; i++) fetch_at(32'(i * 4));
        chk("t2_no_ovf_yet", {31'b0, trace_overflow}, 32'd0);
        fetch_at(32'h20);
        chk("t2_overflow", {31'b0, trace_overflow}, 32'd1);
        chk("t2_fetches", fetch_count, 32'd9);
        trace_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            estado = 6'd1 + 6'(i % 2);
            tick();
        end
        chk("t2_empty", {31'b0, trace_valid}, 32'd0);
        trace_ready = 1'b0;
        do_clear();

        // Test 3: push and pop together on a full FIFO
        for (int i = 0; i < 8; i++) fetch_at(32'(i * 4));
        estado      = FS;
        RegPCOut    = 32'h40;
        trace_ready = 1'b1;
        tick();
        estado      = 6'd1;
        trace_ready = 1'b0;
        tick();
        chk("t3_no_overflow", {31'b0, trace_overflow}, 32'd0);
        chk("t3_still_valid", {31'b0, trace_valid}, 32'd1);
        trace_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            estado = 6'd1 + 6'(i % 2);
            tick();
        end
        chk("t3_last_entry", trace_data, 32'h40);
        tick();
        chk("t3_empty", {31'b0, trace_valid}, 32'd0);
        trace_ready = 1'b0;
        do_clear();

        // Test 4: self-loop at 0x3C; the fifth same-PC fetch declares halt
        for (int k = 1; k <= 5; k++) begin
            estado   = FS;
            RegPCOut = 32'h3C;
            tick();
            chk($sformatf("t4_halt_ev%0d", k), {31'b0, halted}, (k == 5) ? 32'd1 : 32'd0);
            estado = 6'd1;
            tick();
        end
        fetch_at(32'h40);
        chk("t4_halt_sticky", {31'b0, halted}, 32'd1);
        do_clear();

        // Test 5: frozen estado; stall only after the full dwell
        estado = 6'd5;
        repeat (64) tick();
        chk("t5_not_yet", {31'b0, stalled}, 32'd0);
        tick();
        chk("t5_stalled", {31'b0, stalled}, 32'd1);
        do_clear();
        chk("t5_cleared", {31'b0, stalled}, 32'd0);
        estado = 6'd5;
        repeat (64) tick();
        estado = 6'd6;
        tick();
        chk("t5_short_dwell", {31'b0, stalled}, 32'd0);
        estado = 6'd7;
        repeat (3) tick();
        chk("t5_short_dwell_after", {31'b0, stalled}, 32'd0);

        // Test 6: clear swallows a coincident fetch event; async reset mid-run
        fetch_at(32'h100);
        estado   = FS;
        RegPCOut = 32'h200;
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
        chk_all_zero("t6_clear");
        tick();
        chk("t6_cycles_after_clear", cycle_count, 32'd1);
        chk("t6_no_event_in_dwell", fetch_count, 32'd0);
        estado = 6'd1;
        tick();
        fetch_at(32'h300);
        chk("t6_prereset_valid", {31'b0, trace_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("t6_async_reset");
        sb.delete();
        m_prev = ~FS;
        @(posedge clock);
        #1;
        chk("t6_held_in_reset", cycle_count, 32'd0);
        reset    = 1'b1;
        estado   = FS;
        RegPCOut = 32'h10;
        tick();
        chk("t6_resume_cycles", cycle_count, 32'd1);
        chk("t6_resume_fetches", fetch_count, 32'd1);
        chk("t6_resume_data", trace_data, 32'h10);
        estado      = 6'd1;
        trace_ready = 1'b1;
        tick();
        chk("t6_final_empty", {31'b0, trace_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
